if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch_fifo.sv | 79 +++++++
 rtl/if_fetch.sv | 101 ++++++++++
 tb/tb_if_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, the NOP used for bubbles,
// the fetch FSM state encoding and the buffered instruction entry.
package rv_defs;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous buffer of fetched instructions with their addresses. A flush
// empties it in one edge; when empty it shows NOP and the last head address.
module fetch_fifo
  import rv_defs::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = NOP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_inst,
  input  logic [XLEN-1:0]         push_addr,
  input  logic                    pop,
  output logic                    valid,
  output logic [XLEN-1:0]         head_inst,
  output logic [XLEN-1:0]         head_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    store [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] last_addr;
  logic            do_push;
  logic            do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && !full;

  // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      store[wr_ptr] <= '{inst: push_inst, addr: push_addr};
    end
  end

  // Remembers the head address so an empty buffer still reports where it was.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_addr <= '0;
    end else if (valid) begin
      last_addr <= store[rd_ptr].addr;
    end
  end

  assign head_inst = valid ? store[rd_ptr].inst : NOP_INST;
  assign head_addr = valid ? store[rd_ptr].addr : last_addr;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding bus request at a time, responses
// buffered in fetch_fifo, redirects discard everything fetched or in flight.
module if_fetch
  import rv_defs::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  pc_i,
  input  logic                         jump_en_i,
  output logic                         hold_o,
  output logic                         mem_req_o,
  output logic [31:0]                  mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         inst_valid_o,
  output logic [31:0]                  inst_o,
  output logic [31:0]                  inst_addr_o,
  input  logic                         inst_ready_i,
  output logic [1:0]                   fsm_state,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  fetch_state_e state;
  fetch_state_e state_nx;
  logic [31:0]  req_addr;
  logic         granted;
  logic         push;
  logic         pop;
  logic         full;

  // Bus handshake: a request is accepted only in a cycle where mem_req_o and
  // mem_gnt_i are both high; the request may drop without a grant (jump or
  // full buffer). A buffer entry moves to decode when inst_valid_o and
  // inst_ready_i are both high.
  assign mem_req_o  = (state == FETCH_IDLE) && !full && !jump_en_i;
  assign mem_addr_o = pc_i;
  assign granted    = mem_req_o && mem_gnt_i;
  assign hold_o     = !granted;

  assign push = (state == FETCH_WAIT) && mem_rvalid_i && !jump_en_i;
  assign pop  = inst_valid_o && inst_ready_i;

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH_IDLE: begin
        if (granted) state_nx = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem_rvalid_i)   state_nx = FETCH_IDLE;
        else if (jump_en_i) state_nx = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (mem_rvalid_i) state_nx = FETCH_IDLE;
      end
      default: state_nx = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The response carries no address, so the granted PC is kept for the push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_addr <= '0;
    end else if (granted) begin
      req_addr <= pc_i;
    end
  end

  fetch_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .NOP_INST (NOP_INST)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_en_i),
    .push      (push),
    .push_inst (mem_rdata_i),
    .push_addr (req_addr),
    .pop       (pop),
    .valid     (inst_valid_o),
    .head_inst (inst_o),
    .head_addr (inst_addr_o),
    .count     (fifo_count),
    .full      (full)
  );

  assign fsm_state = state;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: PC register and instruction memory models around the
// DUT, a scoreboard of expected {addr, inst} pairs and directed scenarios.
module tb_if_fetch;
  import rv_defs::*;

  localparam logic [31:0] KEY = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        hold;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [1:0]  fsm_state;
  logic [1:0]  fifo_count;

  logic        gnt_en;
  int          lat;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] next_addr = '0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .jump_en_i    (jump_en),
    .hold_o       (hold),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (rvalid),
    .mem_rdata_i  (rdata),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_ready_i (inst_ready),
    .fsm_state    (fsm_state),
    .fifo_count   (fifo_count)
  );

  assign mem_gnt = gnt_en;

  // PC register: jump > hold > +4.
  always @(posedge clk) begin
    if (!rst)          pc <= '0;
    else if (jump_en)  pc <= jump_target;
    else if (!hold)    pc <= pc + 32'd4;
  end

  // Instruction memory: responds lat cycles after the grant, in order.
  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          rvalid <= 1'b1;
          rdata  <= m_addr ^ KEY;
          m_busy <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (mem_req && mem_gnt) begin
        if (lat <= 1) begin
          rvalid <= 1'b1;
          rdata  <= mem_addr ^ KEY;
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= lat - 1;
          m_addr <= mem_addr;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input logic [31:0] addr, input logic any, input int budget,
                          output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && (any || inst_addr == addr)) found = 1'b1;
    end
  endtask

  // Scoreboard: grants must follow the PC sequence; each surviving response
  // queues {addr, addr^KEY}; every decode handshake pops and compares.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_q.delete();
        pend      = 1'b0;
        next_addr = '0;
      end else begin
        if (inst_valid && inst_ready) begin
          check("sb_expected_entry", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_addr", inst_addr, e[63:32]);
            check("sb_inst", inst, e[31:0]);
          end
        end else if (!inst_valid) begin
          check("nop_when_empty", inst, NOP);
        end
        if (pend && rvalid) begin
          if (!jump_en) exp_q.push_back({pend_addr, pend_addr ^ KEY});
          pend = 1'b0;
        end
        if (mem_req && mem_gnt) begin
          check("grant_addr", mem_addr, next_addr);
          pend      = 1'b1;
          pend_addr = next_addr;
          next_addr = next_addr + 32'd4;
        end
        if (jump_en) begin
          exp_q.delete();
          pend      = 1'b0;
          next_addr = jump_target;
        end
      end
    end
  end

  initial begin
    logic        found;
    int          vcnt;
    logic [31:0] pc0;

    rst = 1'b0; jump_en = 1'b0; jump_target = '0;
    inst_ready = 1'b1; gnt_en = 1'b1; lat = 1;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, NOP);
    check("rst_addr", inst_addr, 32'd0);
    check("rst_state", fsm_state, FETCH_IDLE);
    check("rst_count", fifo_count, 2'd0);
    check("rst_req", mem_req, 1'b1);

    // Release: grant cycle, WAIT cycle, then first instruction.
    tick(); rst = 1'b1;
    @(negedge clk);
    check("lat_c0_valid", inst_valid, 1'b0);
    check("lat_c0_hold", hold, 1'b0);
    @(negedge clk);
    check("lat_c1_valid", inst_valid, 1'b0);
    check("lat_c1_state", fsm_state, FETCH_WAIT);
    @(negedge clk);
    check("lat_c2_valid", inst_valid, 1'b1);
    check("lat_c2_addr", inst_addr, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) vcnt++;
    end
    check("duty_cycle", vcnt, 10);

    // Decode stall: buffer fills to 2, request withdrawn, PC held.
    tick(); inst_ready = 1'b0;
    repeat (9) @(negedge clk);
    pc0 = pc;
    @(negedge clk);
    check("stall_count", fifo_count, 2'd2);
    check("stall_req", mem_req, 1'b0);
    check("stall_hold", hold, 1'b1);
    check("stall_valid", inst_valid, 1'b1);
    check("stall_pc", pc, pc0);
    tick(); inst_ready = 1'b1;
    repeat (12) tick();

    // Jump during WAIT: response to 0x10 discarded, 0x100 delivered next.
    lat = 3; jump_target = 32'h10; jump_en = 1'b1;
    tick(); jump_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && mem_addr == 32'h10) found = 1'b1;
    end
    check("grant_0x10_seen", found, 1'b1);
    tick(); jump_target = 32'h100; jump_en = 1'b1;
    tick(); jump_en = 1'b0;
    @(negedge clk);
    check("jump_wait_drain", fsm_state, FETCH_DRAIN);
    check("jump_wait_flushed", inst_valid, 1'b0);
    wait_pop('0, 1'b1, 30, found);
    check("jump_wait_popped", found, 1'b1);
    check("jump_wait_addr", inst_addr, 32'h100);
    check("jump_wait_inst", inst, 32'h100 ^ KEY);

    // Jump in the same cycle as the response.
    tick(); lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rvalid) found = 1'b1;
    end
    check("rvalid_seen", found, 1'b1);
    jump_target = 32'h200; jump_en = 1'b1;
    #1;
    check("jump_rv_req", mem_req, 1'b0);
    tick(); jump_en = 1'b0;
    @(negedge clk);
    check("jump_rv_state", fsm_state, FETCH_IDLE);
    check("jump_rv_count", fifo_count, 2'd0);
    check("jump_rv_valid", inst_valid, 1'b0);
    check("jump_rv_next_req", mem_req, 1'b1);
    check("jump_rv_next_addr", mem_addr, 32'h200);
    wait_pop('0, 1'b1, 20, found);
    check("jump_rv_popped", found, 1'b1);
    check("jump_rv_addr", inst_addr, 32'h200);

    // Grant withheld for 5 cycles: PC stable, one request, no duplicate.
    tick(); gnt_en = 1'b0;
    @(negedge clk);
    pc0 = pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nogrant_hold", hold, 1'b1);
      check("nogrant_pc", pc, pc0);
    end
    check("nogrant_req", mem_req, 1'b1);
    check("nogrant_addr", mem_addr, pc0);
    tick(); gnt_en = 1'b1;
    wait_pop(pc0, 1'b0, 20, found);
    check("nogrant_delivered", found, 1'b1);
    wait_pop('0, 1'b1, 20, found);
    check("nogrant_next_popped", found, 1'b1);
    check("nogrant_no_dup", inst_addr, pc0 + 32'd4);

    // Reset while WAIT with one buffered entry.
    tick(); inst_ready = 1'b0; lat = 3; jump_target = 32'h300; jump_en = 1'b1;
    tick(); jump_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (fsm_state == FETCH_WAIT && fifo_count == 2'd1) found = 1'b1;
    end
    check("wait_with_entry", found, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", inst_valid, 1'b0);
    check("midrst_inst", inst, 32'h00000013);
    check("midrst_addr", inst_addr, 32'd0);
    check("midrst_state", fsm_state, FETCH_IDLE);
    check("midrst_count", fifo_count, 2'd0);
    tick(); rst = 1'b1; inst_ready = 1'b1; lat = 1;
    wait_pop('0, 1'b1, 20, found);
    check("restart_popped", found, 1'b1);
    check("restart_addr", inst_addr, 32'd0);
    check("restart_inst", inst, KEY);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
